can_tx_scheduler: RTL and testbench

Transmit-side scheduler for the CAN controller. It holds NBUF pending transmit mailboxes and picks the highest-priority pending identifier using CAN arbitration order. It hands that identifier to the bit-level transmitter through a request/acknowledge handshake. It then resolves the outcome (success, arbitration loss, error frame) into per-mailbox completion, re-queue, or retry-limited failure.

---
 rtl/can_tx_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: picks the lowest-key pending CAN mailbox, requests it from the
// bit-level transmitter, and resolves done / lost / error outcomes per mailbox.
`default_nettype none

module can_tx_scheduler #(
  parameter int NBUF      = 4,
  parameter int MAX_RETRY = 8,
  localparam int SELW     = (NBUF > 1) ? $clog2(NBUF) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [SELW-1:0] wr_sel,
  input  logic [28:0]     wr_id,
  input  logic            wr_ide,
  input  logic            abort_en,
  input  logic [SELW-1:0] abort_sel,
  input  logic            bus_idle,
  output logic            tx_req,
  output logic [SELW-1:0] tx_sel,
  output logic [28:0]     tx_id,
  output logic            tx_ide,
  input  logic            tx_ack,
  input  logic            tx_done,
  input  logic            tx_lost,
  input  logic            tx_error,
  output logic [NBUF-1:0] pending,
  output logic [NBUF-1:0] done_pulse,
  output logic [NBUF-1:0] fail_pulse,
  output logic            wr_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [28:0]     id_mem    [NBUF];
  logic [NBUF-1:0] ide_mem;
  logic [3:0]      retry_mem [NBUF];
  logic            abort_req;

  logic            in_req, in_active;
  logic [NBUF-1:0] abort_vec, wr_vec, cur_vec, sel_pend;
  logic            abort_cur, abort_eff, req_abort, wr_locked;
  logic            done_ev, err_ev, lost_ev, outcome_ev;
  logic            drop_err, drop_lost;
  logic [3:0]      retry_inc;

  logic [SELW-1:0] win_idx;
  logic [29:0]     win_key;
  logic            win_found;

  // Arbitration order: base id first, then standard before extended, then extension bits.
  function automatic logic [29:0] prio_key(input logic [28:0] id, input logic ide);
    prio_key = {id[28:18], ide, ide ? id[17:0] : 18'b0};
  endfunction

  assign in_req    = (state == S_REQ);
  assign in_active = (state == S_ACTIVE);

  always_comb begin
    abort_vec = '0;
    wr_vec    = '0;
    cur_vec   = '0;
    for (int i = 0; i < NBUF; i++) begin
      abort_vec[i] = abort_en && (abort_sel == SELW'(i));
      wr_vec[i]    = wr_en && (wr_sel == SELW'(i));
      cur_vec[i]   = (in_req || in_active) && (tx_sel == SELW'(i));
    end
  end

  // A mailbox being aborted this cycle must not win the selection it would vanish from.
  assign sel_pend = pending & ~abort_vec;

  always_comb begin
    win_idx   = '0;
    win_key   = '1;
    win_found = 1'b0;
    for (int i = 0; i < NBUF; i++) begin
      if (sel_pend[i] && (!win_found || (prio_key(id_mem[i], ide_mem[i]) < win_key))) begin
        win_found = 1'b1;
        win_key   = prio_key(id_mem[i], ide_mem[i]);
        win_idx   = SELW'(i);
      end
    end
  end

  assign abort_cur  = abort_en && (abort_sel == tx_sel);
  assign abort_eff  = abort_req || (in_active && abort_cur);
  assign req_abort  = in_req && abort_cur;
  assign wr_locked  = wr_en && (in_req || in_active) && (wr_sel == tx_sel);

  assign done_ev    = in_active && tx_done;
  assign err_ev     = in_active && tx_error && !tx_done;
  assign lost_ev    = in_active && tx_lost && !tx_done && !tx_error;
  assign outcome_ev = in_active && (tx_done || tx_error || tx_lost);

  assign retry_inc  = retry_mem[tx_sel] + 4'd1;
  assign drop_err   = err_ev && (abort_eff || (retry_inc == 4'(MAX_RETRY)));
  assign drop_lost  = lost_ev && abort_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if ((|pending) && bus_idle) next_state = S_SELECT;
      S_SELECT: next_state = win_found ? S_REQ : S_IDLE;
      S_REQ: begin
        if (req_abort)   next_state = S_IDLE;
        else if (tx_ack) next_state = S_ACTIVE;
      end
      S_ACTIVE: if (outcome_ev) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_req     <= 1'b0;
      tx_sel     <= '0;
      tx_id      <= '0;
      tx_ide     <= 1'b0;
      busy       <= 1'b0;
      wr_err     <= 1'b0;
      abort_req  <= 1'b0;
      pending    <= '0;
      done_pulse <= '0;
      fail_pulse <= '0;
      ide_mem    <= '0;
      for (int i = 0; i < NBUF; i++) begin
        id_mem[i]    <= '0;
        retry_mem[i] <= '0;
      end
    end else begin
      tx_req <= (next_state == S_REQ);
      busy   <= (next_state == S_REQ) || (next_state == S_ACTIVE);
      wr_err <= wr_locked;

      if ((state == S_SELECT) && win_found) begin
        tx_sel <= win_idx;
        tx_id  <= id_mem[win_idx];
        tx_ide <= ide_mem[win_idx];
      end

      // Abort on the in-flight frame waits for the outcome to decide done vs. dropped.
      if (in_active && !outcome_ev) abort_req <= abort_req || abort_cur;
      else                          abort_req <= 1'b0;

      for (int i = 0; i < NBUF; i++) begin
        if (cur_vec[i]) begin
          done_pulse[i] <= done_ev;
          fail_pulse[i] <= req_abort || drop_err || drop_lost;
          if (req_abort || done_ev || drop_err || drop_lost) begin
            pending[i]   <= 1'b0;
            retry_mem[i] <= '0;
          end else if (err_ev) begin
            retry_mem[i] <= retry_inc;
          end
        end else if (abort_vec[i]) begin
          done_pulse[i] <= 1'b0;
          fail_pulse[i] <= pending[i];
          pending[i]    <= 1'b0;
          retry_mem[i]  <= '0;
        end else begin
          done_pulse[i] <= 1'b0;
          fail_pulse[i] <= 1'b0;
          if (wr_vec[i]) begin
            id_mem[i]    <= wr_ide ? wr_id : {wr_id[10:0], 18'b0};
            ide_mem[i]   <= wr_ide;
            pending[i]   <= 1'b1;
            retry_mem[i] <= '0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_can_tx_scheduler.sv
// Randomized scoreboard bench for can_tx_scheduler against a mailbox-level reference model.
`default_nettype none

module tb_can_tx_scheduler;

  localparam int NB   = 4;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_ide, abort_en, bus_idle, tx_ack, tx_done, tx_lost, tx_error;
  logic [1:0]  wr_sel, abort_sel;
  logic [28:0] wr_id;
  logic        tx_req, tx_ide, wr_err, busy;
  logic [1:0]  tx_sel;
  logic [28:0] tx_id;
  logic [3:0]  pending, done_pulse, fail_pulse;

  can_tx_scheduler #(.NBUF(NB), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_id(wr_id), .wr_ide(wr_ide),
    .abort_en(abort_en), .abort_sel(abort_sel), .bus_idle(bus_idle),
    .tx_req(tx_req), .tx_sel(tx_sel), .tx_id(tx_id), .tx_ide(tx_ide),
    .tx_ack(tx_ack), .tx_done(tx_done), .tx_lost(tx_lost), .tx_error(tx_error),
    .pending(pending), .done_pulse(done_pulse), .fail_pulse(fail_pulse),
    .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [28:0] id;
    logic        ide;
  } req_t;

  req_t       req_q[$];
  logic [3:0] done_q[$];
  logic [3:0] fail_q[$];
  int         werr_q[$];

  int checks = 0;
  int fails  = 0;

  // Reference mailbox state
  logic [28:0] m_id    [NB];
  logic        m_ide   [NB];
  bit          m_pend  [NB];
  int          m_retry [NB];
  bit          in_tx;
  bit          abortf;
  int          cur;
  logic [28:0] exp_id;
  logic        exp_ide;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    checks++;
    fails++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  function automatic logic [28:0] cmp_id(input logic [28:0] id, input logic ide);
    cmp_id = ide ? id : {id[28:18], 18'b0};
  endfunction

  // Lowest arbitration value wins; strict less-than keeps the lower index on ties.
  function automatic int model_winner();
    longint best = 0;
    longint k;
    int     w = -1;
    for (int i = 0; i < NB; i++) begin
      if (m_pend[i]) begin
        k = longint'(m_id[i][28:18]) * 524288;
        if (m_ide[i]) k = k + 262144 + longint'(m_id[i][17:0]);
        if (w < 0 || k < best) begin
          best = k;
          w    = i;
        end
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] pend_vec();
    logic [3:0] v = '0;
    for (int i = 0; i < NB; i++) v[i] = m_pend[i];
    return v;
  endfunction

  req_t mon_r;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (tx_req && !prev_req) begin
        if (req_q.size() == 0) note_fail("req_unexpected", tx_sel);
        else begin
          mon_r = req_q.pop_front();
          check("req_sel", tx_sel, mon_r.sel);
          check("req_ide", tx_ide, mon_r.ide);
          check("req_id", cmp_id(tx_id, tx_ide), cmp_id(mon_r.id, mon_r.ide));
        end
      end
      if (done_pulse != 0) begin
        if (done_q.size() == 0) note_fail("done_unexpected", done_pulse);
        else check("done_pulse", done_pulse, done_q.pop_front());
      end
      if (fail_pulse != 0) begin
        if (fail_q.size() == 0) note_fail("fail_unexpected", fail_pulse);
        else check("fail_pulse", fail_pulse, fail_q.pop_front());
      end
      if (wr_err) begin
        if (werr_q.size() == 0) note_fail("wr_err_unexpected", wr_err);
        else void'(werr_q.pop_front());
      end
      prev_req = tx_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_store(input int s, input logic [28:0] id, input logic ide);
    m_id[s]    = ide ? id : {id[10:0], 18'b0};
    m_ide[s]   = ide;
    m_pend[s]  = 1'b1;
    m_retry[s] = 0;
  endtask

  task automatic model_drop(input int s);
    logic [3:0] mk;
    mk = 4'b0001 << s;
    m_pend[s]  = 1'b0;
    m_retry[s] = 0;
    fail_q.push_back(mk);
  endtask

  // One cycle with an optional write and/or abort (index -1 means none).
  task automatic do_ops(input int wsel, input logic [28:0] wid, input logic wide, input int asel);
    if (asel >= 0) begin
      if (in_tx && asel == cur) abortf = 1'b1;
      else if (m_pend[asel]) model_drop(asel);
      else m_retry[asel] = 0;
    end
    if (wsel >= 0) begin
      if (in_tx && wsel == cur) werr_q.push_back(1);
      else if (wsel != asel) model_store(wsel, wid, wide);
    end
    wr_en     = (wsel >= 0);
    wr_sel    = (wsel >= 0) ? 2'(wsel) : 2'd0;
    wr_id     = wid;
    wr_ide    = wide;
    abort_en  = (asel >= 0);
    abort_sel = (asel >= 0) ? 2'(asel) : 2'd0;
    tick();
    wr_en    = 1'b0;
    abort_en = 1'b0;
  endtask

  task automatic expect_req(output bit ok);
    int w;
    req_t r;
    w  = model_winner();
    ok = (w >= 0);
    if (ok) begin
      r.sel = w; r.id = m_id[w]; r.ide = m_ide[w];
      req_q.push_back(r);
      cur = w; exp_id = m_id[w]; exp_ide = m_ide[w];
      in_tx = 1'b1; abortf = 1'b0;
    end
  endtask

  task automatic request_phase(output bit ok);
    int n;
    expect_req(ok);
    if (ok) begin
      bus_idle = 1'b1;
      n = 0;
      while (!tx_req && n < 20) begin
        tick();
        n++;
      end
      check("req_timeout", tx_req, 1'b1);
      if (!tx_req) begin
        in_tx = 1'b0; ok = 1'b0; bus_idle = 1'b0;
      end
    end
  endtask

  task automatic complete_tx(input int ack_dly, input bit ab_req, input int ex_wsel,
                             input logic [28:0] ex_id, input logic ex_ide,
                             input bit wr_cur, input bit ab_cur, input logic [2:0] outc);
    bus_idle = 1'b0;
    if (ab_req) begin
      abort_en = 1'b1; abort_sel = 2'(cur);
      model_drop(cur);
      tick();
      abort_en = 1'b0;
      in_tx = 1'b0;
      check("req_abort_drop", {tx_req, busy}, 2'b00);
      return;
    end
    repeat (ack_dly) tick();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check("ack_to_active", {tx_req, busy}, 2'b01);
    if (ex_wsel >= 0) do_ops(ex_wsel, ex_id, ex_ide, -1);
    if (wr_cur) begin
      do_ops(cur, 29'h1ABCDEF, 1'b1, -1);
      check("tx_id_hold", cmp_id(tx_id, tx_ide), cmp_id(exp_id, exp_ide));
    end
    if (ab_cur) do_ops(-1, '0, 1'b0, cur);
    tx_done = outc[0]; tx_error = outc[1]; tx_lost = outc[2];
    if (outc[0]) begin
      m_pend[cur] = 1'b0; m_retry[cur] = 0;
      done_q.push_back(4'b0001 << cur);
    end else if (outc[1]) begin
      if (abortf) model_drop(cur);
      else begin
        m_retry[cur]++;
        if (m_retry[cur] == MAXR) model_drop(cur);
      end
    end else if (outc[2]) begin
      if (abortf) model_drop(cur);
    end
    tick();
    tx_done = 1'b0; tx_error = 1'b0; tx_lost = 1'b0;
    in_tx = 1'b0; abortf = 1'b0;
    check("pending_after_outcome", pending, pend_vec());
    check("busy_after_outcome", busy, 1'b0);
  endtask

  task automatic send(input logic [2:0] outc);
    bit ok;
    request_phase(ok);
    if (ok) complete_tx(0, 1'b0, -1, '0, 1'b0, 1'b0, 1'b0, outc);
  endtask

  task automatic rand_id(output logic [28:0] id, output logic ide);
    logic [10:0] bases [4];
    logic [10:0] b;
    bases[0] = 11'h091; bases[1] = 11'h010; bases[2] = 11'h123; bases[3] = 11'h7FF;
    b   = bases[$urandom_range(0, 3)];
    ide = 1'($urandom_range(0, 1));
    if (ide) id = {b, ($urandom_range(0, 2) == 0) ? 18'h0 : 18'($urandom)};
    else     id = {18'($urandom), b};
  endtask

  initial begin
    bit          ok;
    int          lat;
    logic [28:0] rid;
    logic        ride;

    reset = 1'b1;
    wr_en = 0; wr_sel = 0; wr_id = 0; wr_ide = 0; abort_en = 0; abort_sel = 0;
    bus_idle = 0; tx_ack = 0; tx_done = 0; tx_lost = 0; tx_error = 0;
    in_tx = 0; abortf = 0; cur = 0; exp_id = 0; exp_ide = 0;
    for (int i = 0; i < NB; i++) begin
      m_id[i] = 0; m_ide[i] = 0; m_pend[i] = 0; m_retry[i] = 0;
    end
    tick(); tick();
    check("reset_outputs", {tx_req, busy, wr_err, tx_ide, tx_sel, pending, done_pulse, fail_pulse}, '0);
    check("reset_tx_id", tx_id, '0);
    reset = 1'b0;
    tick();

    // Write-to-request latency with bus already idle
    model_store(2, 29'h123, 1'b0);
    expect_req(ok);
    wr_en = 1; wr_sel = 2; wr_id = 29'h123; wr_ide = 0; bus_idle = 1;
    tick();
    wr_en = 0;
    lat = 1;
    while (!tx_req && lat < 10) begin
      tick();
      lat++;
    end
    check("req_latency", lat, 3);
    check("pending_mb2", pending, 4'b0100);
    complete_tx(1, 1'b0, -1, '0, 1'b0, 1'b0, 1'b0, 3'b001);

    // Priority: std beats ext on equal base, lower index wins ties
    do_ops(0, 29'h0246_8ACE, 1'b1, -1);
    do_ops(1, 29'h091, 1'b0, -1);
    do_ops(3, 29'h091, 1'b0, -1);
    send(3'b001); send(3'b001); send(3'b001);

    // Arbitration loss with a lower id loaded during ACTIVE
    do_ops(1, 29'h091, 1'b0, -1);
    request_phase(ok);
    if (ok) complete_tx(0, 1'b0, 0, 29'h010, 1'b0, 1'b0, 1'b0, 3'b100);
    send(3'b001); send(3'b001);

    // Retry limit, then two errors followed by success
    do_ops(0, 29'h055, 1'b0, -1);
    send(3'b010); send(3'b010); send(3'b010);
    do_ops(0, 29'h055, 1'b0, -1);
    send(3'b010); send(3'b010); send(3'b001);

    // Aborts and rejected writes around an active frame
    do_ops(2, 29'h0ABCDEF, 1'b1, -1);
    request_phase(ok);
    if (ok) complete_tx(0, 1'b0, -1, '0, 1'b0, 1'b0, 1'b1, 3'b010);
    do_ops(2, 29'h0ABCDEF, 1'b1, -1);
    request_phase(ok);
    if (ok) complete_tx(0, 1'b0, -1, '0, 1'b0, 1'b0, 1'b1, 3'b001);
    do_ops(2, 29'h0ABCDEF, 1'b1, -1);
    request_phase(ok);
    if (ok) complete_tx(0, 1'b0, -1, '0, 1'b0, 1'b1, 1'b0, 3'b001);
    do_ops(1, 29'h200, 1'b0, -1);
    request_phase(ok);
    if (ok) complete_tx(0, 1'b1, -1, '0, 1'b0, 1'b0, 1'b0, 3'b001);

    // Same-cycle write/abort combinations on idle mailboxes
    do_ops(3, 29'h300, 1'b0, -1);
    do_ops(3, 29'h301, 1'b0, 3);
    do_ops(3, 29'h302, 1'b0, 3);
    do_ops(1, 29'h111, 1'b0, 2);
    check("pending_wr_abort", pending, pend_vec());
    send(3'b001);

    for (int it = 0; it < 150; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        rand_id(rid, ride);
        case ($urandom_range(0, 3))
          0, 1:    do_ops($urandom_range(0, 3), rid, ride, -1);
          2:       do_ops(-1, rid, ride, $urandom_range(0, 3));
          default: do_ops($urandom_range(0, 3), rid, ride, $urandom_range(0, 3));
        endcase
      end
      request_phase(ok);
      if (ok) begin
        rand_id(rid, ride);
        complete_tx($urandom_range(0, 2), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
                    rid, ride, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    3'($urandom_range(1, 7)));
      end
    end
    check("pending_random_end", pending, pend_vec());

    // Reset in the middle of a transmission
    for (int i = 0; i < NB; i++) if (m_pend[i]) do_ops(-1, '0, 1'b0, i);
    do_ops(0, 29'h040, 1'b0, -1);
    do_ops(1, 29'h041, 1'b0, -1);
    do_ops(2, 29'h042, 1'b0, -1);
    request_phase(ok);
    bus_idle = 1'b0;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midtx_reset_outputs", {tx_req, busy, wr_err, tx_ide, tx_sel, pending, done_pulse, fail_pulse}, '0);
    check("midtx_reset_tx_id", tx_id, '0);
    for (int i = 0; i < NB; i++) begin
      m_pend[i] = 0; m_retry[i] = 0;
    end
    in_tx = 0;
    tick();
    reset = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("post_reset_done_ignored", {done_pulse, pending, busy}, '0);
    tick(); tick();

    check("req_q_drained", req_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("fail_q_drained", fail_q.size(), 0);
    check("werr_q_drained", werr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
